// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier between N_REQ clients.
// Each accepted op carries a tag down a fixed-latency pipe so its result returns with the requester id.
module fp_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*32-1:0]   req_x,
  input  logic [N_REQ*32-1:0]   req_y,
  input  logic [N_REQ*3-1:0]    req_rmode,
  input  logic                  drain,
  output logic [2:0]            mul_r_mode,
  output logic [31:0]           mul_fp_X,
  output logic [31:0]           mul_fp_Y,
  input  logic [31:0]           mul_fp_Z,
  input  logic                  mul_ovrf,
  input  logic                  mul_udrf,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_z,
  output logic                  rsp_ovrf,
  output logic                  rsp_udrf,
  output logic                  rsp_err,
  output logic                  idle
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_id;
  logic             found;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] grant;
  logic [2:0]       sel_rmode;
  logic             illegal;
  logic             busy;
  int               idx;
  tag_t             tag_pipe [MUL_LAT:0];

  // First candidate at or above the pointer wins, wrapping past N_REQ-1.
  always_comb begin
    cand   = req_valid & ~{N_REQ{drain}};
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && cand[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        win_id      = ID_W'(idx);
      end
    end
    if (rst) begin
      grant = '0;
      found = 1'b0;
    end
  end

  assign req_ready = grant;
  assign sel_rmode = req_rmode[3*int'(win_id) +: 3];
  assign illegal   = (sel_rmode >= 3'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      mul_r_mode <= '0;
      mul_fp_X   <= '0;
      mul_fp_Y   <= '0;
    end else if (found) begin
      ptr <= (int'(win_id) == N_REQ-1) ? '0 : win_id + ID_W'(1);
      // Illegal modes are acknowledged but never reach the multiplier.
      if (!illegal) begin
        mul_r_mode <= sel_rmode;
        mul_fp_X   <= req_x[32*int'(win_id) +: 32];
        mul_fp_Y   <= req_y[32*int'(win_id) +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= MUL_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= '{vld: found, id: win_id, err: found & illegal};
      for (int k = 1; k <= MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_z     <= '0;
      rsp_ovrf  <= 1'b0;
      rsp_udrf  <= 1'b0;
    end else begin
      rsp_valid <= tag_pipe[MUL_LAT].vld;
      rsp_id    <= tag_pipe[MUL_LAT].vld ? tag_pipe[MUL_LAT].id : '0;
      rsp_err   <= tag_pipe[MUL_LAT].vld & tag_pipe[MUL_LAT].err;
      if (tag_pipe[MUL_LAT].vld && !tag_pipe[MUL_LAT].err) begin
        rsp_z    <= mul_fp_Z;
        rsp_ovrf <= mul_ovrf;
        rsp_udrf <= mul_udrf;
      end else begin
        rsp_z    <= '0;
        rsp_ovrf <= 1'b0;
        rsp_udrf <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) busy = busy | tag_pipe[k].vld;
  end

  assign idle = ~busy & ~found;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: RR grant model plus a response scoreboard fed by a stub multiplier.
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int L = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*32-1:0] req_x, req_y;
  logic [N*3-1:0] req_rmode;
  logic drain;
  logic [2:0] mul_r_mode;
  logic [31:0] mul_fp_X, mul_fp_Y, mul_fp_Z;
  logic mul_ovrf, mul_udrf;
  logic rsp_valid, rsp_ovrf, rsp_udrf, rsp_err, idle;
  logic [IW-1:0] rsp_id;
  logic [31:0] rsp_z;

  fp_mul_arbiter #(.N_REQ(N), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode), .drain(drain),
    .mul_r_mode(mul_r_mode), .mul_fp_X(mul_fp_X), .mul_fp_Y(mul_fp_Y),
    .mul_fp_Z(mul_fp_Z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf), .rsp_err(rsp_err), .idle(idle)
  );

  always #5 clk = ~clk;

  // Toy multiplier: exact for power-of-two operands, flags on exponent range.
  function automatic logic [33:0] fmul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    logic s; int e; logic [22:0] m;
    s = x[31] ^ y[31];
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    m = x[22:0] ^ y[22:0] ^ {20'b0, rm};
    if (e >= 255) return {2'b10, s, 8'hFF, 23'b0};
    if (e <= 0)   return {2'b01, s, 31'b0};
    return {2'b00, s, e[7:0], m};
  endfunction

  logic [33:0] st0, st1;
  always @(posedge clk) begin
    st0 <= fmul(mul_fp_X, mul_fp_Y, mul_r_mode);
    st1 <= st0;
  end
  assign {mul_ovrf, mul_udrf, mul_fp_Z} = st1;

  typedef struct {
    int due;
    logic [IW-1:0] id;
    logic [31:0] z;
    logic ov, ud, err;
  } ent_t;

  ent_t sb[$];
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int tb_ptr = 0;
  logic [2:0] exp_rm = '0;
  logic [31:0] exp_x = '0, exp_y = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every rsp must match the scoreboard head on its due cycle.
  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0 || sb[0].due != cyc) begin
          $display("FAIL rsp_unexpected cyc=%0d id=%0d z=%h", cyc, rsp_id, rsp_z);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_err} !== {e.id, e.z, e.ov, e.ud, e.err})
            $display("FAIL rsp_fields cyc=%0d got id=%0d z=%h o=%b u=%b e=%b exp id=%0d z=%h o=%b u=%b e=%b",
                     cyc, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_err, e.id, e.z, e.ov, e.ud, e.err);
          else passes++;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          checks++;
          $display("FAIL rsp_missing cyc=%0d exp id=%0d", cyc, sb[0].id);
          void'(sb.pop_front());
        end
        checks++;
        if ({rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_err} !== '0)
          $display("FAIL rsp_idle_zero cyc=%0d got z=%h id=%0d", cyc, rsp_z, rsp_id);
        else passes++;
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
    req_rmode[3*i +: 3] = rm;
  endtask

  // One clock: predict grant/idle, push expected response, then verify operand bus.
  task automatic tick();
    logic [N-1:0] cand, exp_rdy;
    logic [2:0] rm;
    int w;
    bit inflight, was_rst;
    ent_t e;
    @(negedge clk);
    was_rst = rst;
    cand = req_valid & ~{N{drain}};
    exp_rdy = '0;
    w = -1;
    if (!rst)
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (tb_ptr + k) % N;
        if (w < 0 && cand[idx]) begin w = idx; exp_rdy[idx] = 1'b1; end
      end
    checks++;
    if (req_ready !== exp_rdy) $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
    else passes++;
    if (!rst) begin
      inflight = 0;
      foreach (sb[j]) if (sb[j].due >= cyc + 1 && sb[j].due <= cyc + 1 + L) inflight = 1;
      checks++;
      if (idle !== (!inflight && w < 0)) $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, idle, !inflight && w < 0);
      else passes++;
    end
    if (rst) begin
      sb.delete();
      tb_ptr = 0;
      exp_rm = '0; exp_x = '0; exp_y = '0;
    end else if (w >= 0) begin
      rm = req_rmode[3*w +: 3];
      e.due = cyc + 2 + L;
      e.id = IW'(w);
      e.err = (rm >= 3'd5);
      if (e.err) begin
        e.z = '0; e.ov = 0; e.ud = 0;
      end else begin
        {e.ov, e.ud, e.z} = fmul(req_x[32*w +: 32], req_y[32*w +: 32], rm);
        exp_rm = rm; exp_x = req_x[32*w +: 32]; exp_y = req_y[32*w +: 32];
      end
      sb.push_back(e);
      tb_ptr = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    if (w >= 0 || was_rst) begin
      checks++;
      if ({mul_r_mode, mul_fp_X, mul_fp_Y} !== {exp_rm, exp_x, exp_y})
        $display("FAIL mul_operands cyc=%0d got %h %h %h exp %h %h %h", cyc, mul_r_mode, mul_fp_X, mul_fp_Y, exp_rm, exp_x, exp_y);
      else passes++;
    end
  endtask

  task automatic wait_flush();
    int n = 0;
    while (sb.size() > 0 && n < 30) begin tick(); n++; end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL flush_timeout pending=%0d", sb.size());
      sb.delete();
    end else passes++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; drain = 0; req_valid = '1;
    req_x = '0; req_y = '0; req_rmode = '0;
    tick(); tick();
    req_valid = '0; rst = 0;
    #2;
    checks++;
    if ({req_ready, mul_r_mode, mul_fp_X, mul_fp_Y, rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_err, idle} !== {{(N+3+64+1+IW+32+3){1'b0}}, 1'b1})
      $display("FAIL reset_state got rdy=%b X=%h rsp_v=%b idle=%b", req_ready, mul_fp_X, rsp_valid, idle);
    else passes++;
    tick();
  endtask

  task automatic test_single();
    set_req(1, 32'h3F800000, 32'h40000000, 3'd0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_flush();
  endtask

  task automatic test_rr();
    for (int i = 0; i < N; i++) set_req(i, 32'h3F800000 + (i << 23), 32'h40000000 + i, 3'(i));
    req_valid = '1;
    repeat (8) tick();
    req_valid = '0;
    wait_flush();
  endtask

  task automatic test_flags();
    set_req(2, 32'h7F000000, 32'h7F000000, 3'd0);
    req_valid = 4'b0100;
    tick();
    set_req(0, 32'h00800000, 32'h00800000, 3'd1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_flush();
  endtask

  task automatic test_illegal();
    set_req(3, 32'h40400000, 32'h40400000, 3'd6);
    req_valid = 4'b1000;
    tick();
    set_req(3, 32'h3F800000, 32'h3F800000, 3'd7);
    set_req(2, 32'h3F800000, 32'h40800000, 3'd4);
    req_valid = 4'b1100;
    tick(); tick();
    req_valid = '0;
    wait_flush();
  endtask

  task automatic test_drain();
    set_req(1, 32'h40000000, 32'h40000000, 3'd2);
    req_valid = 4'b0010;
    repeat (3) tick();
    drain = 1;
    repeat (6) tick();
    wait_flush();
    checks++;
    if (idle !== 1'b1) $display("FAIL drain_idle got=%b exp=1", idle);
    else passes++;
    drain = 0;
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'h40000000, 32'h3F800000, 3'd0);
    req_valid = 4'b0001;
    tick(); tick();
    req_valid = '0;
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (idle !== 1'b1) $display("FAIL idle_after_rst got=%b exp=1", idle);
    else passes++;
    set_req(3, 32'h3F800000, 32'h3F800000, 3'd0);
    req_valid = 4'b1001;
    tick();
    req_valid = '0;
    repeat (6) tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, {1'b0, 8'($urandom_range(40, 200)), 23'($urandom)},
                   {1'b0, 8'($urandom_range(40, 200)), 23'($urandom)}, 3'($urandom_range(0, 7)));
      req_valid = 4'($urandom);
      drain = ($urandom_range(0, 9) == 0);
      tick();
    end
    req_valid = '0; drain = 0;
    wait_flush();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_flags();
    test_illegal();
    test_drain();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
